alien_bomb: RTL and testbench

- Downward-travelling counterpart of the player shot: manages up to NUM_BOMBS alien bombs dropped from an alien-selected origin toward the ship.
- Decides when to fire (cooldown plus LFSR randomness), moves bombs down on each movement tick, renders them for the pixel pipeline, and reports ship collisions.
- Sits between the alien controller (supplies fire origin) and the game-state logic (consumes player_hit); bomb_pixel is ORed into the video mux.

---
 rtl/alien_bomb_pkg.sv | 47 ++++
 rtl/alien_bomb_if.sv | 52 +++++
 rtl/alien_bomb_slot.sv | 71 +++++++
 rtl/alien_bomb.sv | 106 ++++++++++
 tb/tb_alien_bomb.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alien_bomb_pkg.sv
// Shared game geometry and helpers for the shot, ship and bomb blocks.
// Coordinates are 11 bits; rectangle tests widen to 12 bits so they never wrap.
package alien_bomb_pkg;

    localparam int GAME_COORD_W     = 11;
    localparam int GAME_SCREEN_W    = 800;
    localparam int GAME_SCREEN_H    = 600;

    localparam int GAME_BOMB_SPEED  = 2;
    localparam int GAME_BOMB_WIDTH  = 4;
    localparam int GAME_BOMB_HEIGHT = 10;

    localparam int GAME_SHOT_SPEED  = 4;
    localparam int GAME_SHOT_WIDTH  = 2;
    localparam int GAME_SHOT_HEIGHT = 8;

    // Feedback taps x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3.
    localparam logic [7:0] GAME_LFSR_TAPS = 8'hB8;

    typedef logic [GAME_COORD_W-1:0] coord_t;
    typedef logic [GAME_COORD_W:0]   wcoord_t;

    function automatic logic in_rect(
        input coord_t  px,
        input coord_t  py,
        input coord_t  rx,
        input coord_t  ry,
        input wcoord_t w,
        input wcoord_t h
    );
        wcoord_t ex;
        wcoord_t ey;
        wcoord_t ox;
        wcoord_t oy;
        ex = {1'b0, px};
        ey = {1'b0, py};
        ox = {1'b0, rx};
        oy = {1'b0, ry};
        return (ex >= ox) && (ex < ox + w) &&
               (ey >= oy) && (ey < oy + h);
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & GAME_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/alien_bomb_if.sv
// Control / video bundle between the game logic and the bomb block.
// master drives ticks, fire origin and scan position; slave answers.
interface alien_bomb_if
    import alien_bomb_pkg::*;
#(
    parameter int NUM_BOMBS = 3
);

    logic                 en;
    logic                 move_tick;
    coord_t               fire_x;
    coord_t               fire_y;
    logic                 fire_valid;
    logic                 fire_ack;
    coord_t               pixel_x;
    coord_t               pixel_y;
    logic                 ship_pixel;
    logic                 bomb_pixel;
    logic                 player_hit;
    logic [NUM_BOMBS-1:0] bombs_active;

    modport master (
        output en,
        output move_tick,
        output fire_x,
        output fire_y,
        output fire_valid,
        output pixel_x,
        output pixel_y,
        output ship_pixel,
        input  fire_ack,
        input  bomb_pixel,
        input  player_hit,
        input  bombs_active
    );

    modport slave (
        input  en,
        input  move_tick,
        input  fire_x,
        input  fire_y,
        input  fire_valid,
        input  pixel_x,
        input  pixel_y,
        input  ship_pixel,
        output fire_ack,
        output bomb_pixel,
        output player_hit,
        output bombs_active
    );

endinterface

// File: rtl/alien_bomb_slot.sv
// One bomb slot: position, launch load, downward move, bottom retire,
// plus its own rectangle test against the scan pixel and the ship.
module bomb_slot
    import alien_bomb_pkg::*;
#(
    parameter int SPEED    = GAME_BOMB_SPEED,
    parameter int WIDTH    = GAME_BOMB_WIDTH,
    parameter int HEIGHT   = GAME_BOMB_HEIGHT,
    parameter int SCREEN_H = GAME_SCREEN_H
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_clr,
    input  logic   i_move,
    input  logic   i_load,
    input  logic   i_ship,
    input  coord_t i_x,
    input  coord_t i_y,
    input  coord_t i_px,
    input  coord_t i_py,
    output logic   o_active,
    output logic   o_cover,
    output logic   o_hit
);

    logic   r_active;
    coord_t r_bx;
    coord_t r_by;

    logic   w_cover;
    logic   w_hit;
    logic   w_retire;

    assign w_cover = r_active &&
                     in_rect(i_px, i_py, r_bx, r_by,
                             wcoord_t'(WIDTH),
                             wcoord_t'(HEIGHT));

    assign w_hit = w_cover && i_ship;

    assign w_retire = ({1'b0, r_by}
                       + wcoord_t'(HEIGHT)
                       + wcoord_t'(SPEED))
                      > wcoord_t'(SCREEN_H);

    // Clear beats hit, hit beats launch/move; a free slot only loads.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_active <= 1'b0;
            r_bx     <= '0;
            r_by     <= '0;
        end else if (w_hit) begin
            r_active <= 1'b0;
        end else if (i_load && !r_active) begin
            r_active <= 1'b1;
            r_bx     <= i_x;
            r_by     <= i_y;
        end else if (r_active && i_move) begin
            if (w_retire) begin
                r_active <= 1'b0;
            end else begin
                r_by <= r_by + coord_t'(SPEED);
            end
        end
    end

    assign o_active = r_active;
    assign o_cover  = w_cover;
    assign o_hit    = w_hit;

endmodule

// File: rtl/alien_bomb.sv
// Alien bomb manager: fire timing (cooldown + LFSR), slot allocation,
// pixel OR for the video mux and ship-collision pulse.
module alien_bomb
    import alien_bomb_pkg::*;
#(
    parameter int         NUM_BOMBS     = 3,
    parameter int         BOMB_SPEED    = GAME_BOMB_SPEED,
    parameter int         BOMB_WIDTH    = GAME_BOMB_WIDTH,
    parameter int         BOMB_HEIGHT   = GAME_BOMB_HEIGHT,
    parameter int         SCREEN_H      = GAME_SCREEN_H,
    parameter int         FIRE_INTERVAL = 48,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input logic         clk_0,
    input logic         rst,
    alien_bomb_if.slave bus
);

    localparam logic [15:0] CD_RELOAD = 16'(FIRE_INTERVAL);

    logic [7:0]           r_lfsr;
    logic [15:0]          r_cooldown;
    logic                 r_fire_ack;
    logic                 r_player_hit;

    logic [NUM_BOMBS-1:0] w_active;
    logic [NUM_BOMBS-1:0] w_cover;
    logic [NUM_BOMBS-1:0] w_hit;
    logic [NUM_BOMBS-1:0] w_free;
    logic [NUM_BOMBS-1:0] w_sel;
    logic                 w_found;
    logic                 w_launch;

    assign w_free = ~w_active;

    // Lowest-index free slot gets the next bomb.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_BOMBS; k++) begin
            if (w_free[k] && !w_found) begin
                w_sel[k] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign w_launch = bus.en && bus.move_tick &&
                      (r_cooldown == '0) &&
                      bus.fire_valid && (|w_free) &&
                      (r_lfsr[1:0] == 2'b00);

    for (genvar k = 0; k < NUM_BOMBS; k++) begin : g_slot
        bomb_slot #(
            .SPEED    (BOMB_SPEED),
            .WIDTH    (BOMB_WIDTH),
            .HEIGHT   (BOMB_HEIGHT),
            .SCREEN_H (SCREEN_H)
        ) u_slot (
            .i_clk    (clk_0),
            .i_rst    (rst),
            .i_clr    (!bus.en),
            .i_move   (bus.move_tick),
            .i_load   (w_launch && w_sel[k]),
            .i_ship   (bus.ship_pixel),
            .i_x      (bus.fire_x),
            .i_y      (bus.fire_y),
            .i_px     (bus.pixel_x),
            .i_py     (bus.pixel_y),
            .o_active (w_active[k]),
            .o_cover  (w_cover[k]),
            .o_hit    (w_hit[k])
        );
    end

    // Fire timing and one-cycle pulses; the LFSR is held (not reseeded) when en drops.
    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_lfsr       <= LFSR_SEED;
            r_cooldown   <= CD_RELOAD;
            r_fire_ack   <= 1'b0;
            r_player_hit <= 1'b0;
        end else if (!bus.en) begin
            r_cooldown   <= CD_RELOAD;
            r_fire_ack   <= 1'b0;
            r_player_hit <= 1'b0;
        end else begin
            r_fire_ack   <= w_launch;
            r_player_hit <= |w_hit;
            if (bus.move_tick) begin
                r_lfsr <= lfsr_next(r_lfsr);
                if (w_launch) begin
                    r_cooldown <= CD_RELOAD;
                end else if (r_cooldown != '0) begin
                    r_cooldown <= r_cooldown - 16'd1;
                end
            end
        end
    end

    assign bus.fire_ack     = r_fire_ack;
    assign bus.player_hit   = r_player_hit;
    assign bus.bomb_pixel   = |w_cover;
    assign bus.bombs_active = w_active;

endmodule

// File: tb/tb_alien_bomb.sv
// Directed bench for alien_bomb: pixel vector table plus
// hand-built launch, hit, retire, full-slot and clear sequences.
module tb_alien_bomb;
    import alien_bomb_pkg::*;

    localparam int NB = 3;
    localparam int FI = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alien_bomb_if #(.NUM_BOMBS(NB)) bif();

    alien_bomb #(
        .NUM_BOMBS     (NB),
        .FIRE_INTERVAL (FI)
    ) dut (
        .clk_0 (clk),
        .rst   (rst),
        .bus   (bif)
    );

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic        exp_pix;
    } vec_t;

    vec_t vt[8];

    int         checks = 0;
    int         errors = 0;
    int         ticks  = 0;
    logic [7:0] m_lfsr;
    int         m_cd;
    bit         m_full;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit exp_l;
        exp_l = bif.en && (m_cd == 0) && bif.fire_valid &&
                !m_full && (m_lfsr[1:0] == 2'b00);
        bif.move_tick = 1'b1;
        cycle();
        bif.move_tick = 1'b0;
        if (bif.en) begin
            if (exp_l) m_cd = FI;
            else if (m_cd != 0) m_cd--;
            m_lfsr = {m_lfsr[6:0],
                      m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
        ticks++;
        check("fire_ack", {31'd0, bif.fire_ack}, {31'd0, exp_l});
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        bif.fire_valid = 1'b0;
        while (!(m_cd == 0 && m_lfsr[1:0] == 2'b00) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("wait_ready_timeout", 1, 0);
    endtask

    task automatic do_launch(input logic [10:0] x,
                             input logic [10:0] y,
                             input logic [NB-1:0] exp_act);
        bif.fire_x     = x;
        bif.fire_y     = y;
        bif.fire_valid = 1'b1;
        tick();
        bif.fire_valid = 1'b0;
        check("launch_active", 32'(bif.bombs_active), 32'(exp_act));
        cycle();
        check("ack_pulse_end", {31'd0, bif.fire_ack}, 0);
    endtask

    task automatic pix(input string name,
                       input logic [10:0] x,
                       input logic [10:0] y,
                       input logic e);
        bif.pixel_x = x;
        bif.pixel_y = y;
        #1;
        check(name, {31'd0, bif.bomb_pixel}, {31'd0, e});
    endtask

    task automatic pix_off();
        bif.pixel_x    = 11'd2000;
        bif.pixel_y    = 11'd2000;
        bif.ship_pixel = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t1;
        int y;

        vt[0] = '{11'd100, 11'd206, 1'b1};
        vt[1] = '{11'd103, 11'd215, 1'b1};
        vt[2] = '{11'd101, 11'd210, 1'b1};
        vt[3] = '{11'd104, 11'd210, 1'b0};
        vt[4] = '{11'd99,  11'd210, 1'b0};
        vt[5] = '{11'd100, 11'd216, 1'b0};
        vt[6] = '{11'd100, 11'd205, 1'b0};
        vt[7] = '{11'd103, 11'd206, 1'b1};

        bif.en         = 1'b1;
        bif.move_tick  = 1'b0;
        bif.fire_x     = '0;
        bif.fire_y     = '0;
        bif.fire_valid = 1'b0;
        m_full         = 1'b0;
        pix_off();

        rst = 1'b1;
        cycle();
        cycle();
        check("rst_active", 32'(bif.bombs_active), 0);
        check("rst_pixel", {31'd0, bif.bomb_pixel}, 0);
        check("rst_ack", {31'd0, bif.fire_ack}, 0);
        check("rst_hit", {31'd0, bif.player_hit}, 0);
        check("rst_lfsr", 32'(dut.r_lfsr), 32'h A5);
        check("rst_cd", 32'(dut.r_cooldown), FI);
        rst    = 1'b0;
        m_lfsr = 8'hA5;
        m_cd   = FI;

        wait_ready(n);
        check("first_wait", n, 4);
        do_launch(11'd100, 11'd200, 3'b001);
        pix("pix_origin", 11'd100, 11'd200, 1'b1);
        tick();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            pix($sformatf("pix_vec%0d", i), vt[i].px, vt[i].py, vt[i].exp_pix);
        end
        pix_off();

        wait_ready(n);
        check("second_wait", n, 8);
        do_launch(11'd300, 11'd500, 3'b011);
        pix("slot0_y224", 11'd100, 11'd224, 1'b1);
        pix("slot0_y223", 11'd100, 11'd223, 1'b0);

        bif.pixel_x    = 11'd301;
        bif.pixel_y    = 11'd505;
        bif.ship_pixel = 1'b1;
        tick();
        check("hit_pulse", {31'd0, bif.player_hit}, 1);
        check("hit_retire", 32'(bif.bombs_active), 3'b001);
        pix_off();
        cycle();
        check("hit_one_cycle", {31'd0, bif.player_hit}, 0);

        wait_ready(n);
        do_launch(11'd300, 11'd500, 3'b011);
        t1 = ticks;
        wait_ready(n);
        y = 500 + 2 * (ticks - t1 + 1);
        do_launch(11'd300, 11'(y), 3'b111);
        pix("dual_in", 11'd302, 11'(y + 9), 1'b1);
        pix("dual_below", 11'd302, 11'(y + 10), 1'b0);
        bif.pixel_y    = 11'(y + 9);
        bif.ship_pixel = 1'b1;
        cycle();
        check("dual_hit", {31'd0, bif.player_hit}, 1);
        check("dual_retire", 32'(bif.bombs_active), 3'b001);
        pix_off();
        cycle();
        check("dual_one_pulse", {31'd0, bif.player_hit}, 0);

        wait_ready(n);
        do_launch(11'd700, 11'd300, 3'b011);
        pix("en_before", 11'd701, 11'd301, 1'b1);
        bif.en = 1'b0;
        cycle();
        check("en_clear", 32'(bif.bombs_active), 0);
        check("en_pixel", {31'd0, bif.bomb_pixel}, 0);
        check("en_cd", 32'(dut.r_cooldown), FI);
        m_cd = FI;
        tick();
        check("en_lfsr_held", 32'(dut.r_lfsr), 32'(m_lfsr));
        bif.en = 1'b1;
        pix_off();

        wait_ready(n);
        do_launch(11'd50, 11'd588, 3'b001);
        tick();
        pix("bot_590", 11'd50, 11'd590, 1'b1);
        pix("bot_589", 11'd50, 11'd589, 1'b0);
        pix("bot_599", 11'd50, 11'd599, 1'b1);
        pix_off();
        tick();
        check("bot_retire", 32'(bif.bombs_active), 0);
        check("bot_nohit", {31'd0, bif.player_hit}, 0);

        wait_ready(n);
        do_launch(11'd50, 11'd595, 3'b001);
        tick();
        check("low_launch_retire", 32'(bif.bombs_active), 0);

        wait_ready(n);
        do_launch(11'd100, 11'd0, 3'b001);
        wait_ready(n);
        do_launch(11'd200, 11'd0, 3'b011);
        t1 = ticks;
        wait_ready(n);
        do_launch(11'd300, 11'd0, 3'b111);
        m_full         = 1'b1;
        bif.fire_valid = 1'b1;
        n = 0;
        while (!(m_cd == 0 && m_lfsr[1:0] == 2'b00) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("full_wait_timeout", 1, 0);
        tick();
        check("full_no_launch", 32'(bif.bombs_active), 3'b111);
        bif.fire_valid = 1'b0;
        y = 2 * (ticks - t1);
        bif.pixel_x    = 11'd201;
        bif.pixel_y    = 11'(y);
        bif.ship_pixel = 1'b1;
        cycle();
        check("full_hit1", {31'd0, bif.player_hit}, 1);
        check("full_free1", 32'(bif.bombs_active), 3'b101);
        pix_off();
        m_full = 1'b0;
        wait_ready(n);
        do_launch(11'd600, 11'd50, 3'b111);
        pix("refill_pos", 11'd601, 11'd50, 1'b1);

        bif.pixel_x    = 11'd601;
        bif.pixel_y    = 11'd51;
        bif.ship_pixel = 1'b1;
        rst = 1'b1;
        cycle();
        check("rst_hit_none", {31'd0, bif.player_hit}, 0);
        check("rst_hit_clear", 32'(bif.bombs_active), 0);
        check("rst_hit_lfsr", 32'(dut.r_lfsr), 32'h A5);
        rst = 1'b0;
        pix_off();
        cycle();
        check("rst_hit_after", {31'd0, bif.player_hit}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
